// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
package reg_wb_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = $clog2(NREG);

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One candidate write: source valid, destination register, data.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/reg_wb_ctrl_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register.
// Gates load issue on WAW and raises decode stall on RAW.
module wb_scoreboard
  import reg_wb_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_vld,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             clr_vld,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  output logic             issue_ready,
  output logic             stall,
  output logic [NREG-1:0]  busy
);

  // x0 never carries a pending load.
  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic            issue_acc;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Issue gating and hazard detection against the current busy vector.
  always_comb begin
    issue_ready = !rst && (!busy[issue_rd] || issue_rd == REG_ZERO);
    issue_acc   = issue_vld && issue_ready;
    stall       = (busy[ra1] && ra1 != REG_ZERO) ||
                  (busy[ra2] && ra2 != REG_ZERO);
  end

  // One-hot set/clear masks for this cycle's issue and response.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_acc && issue_rd != REG_ZERO) set_mask[issue_rd] = 1'b1;
    if (clr_vld)                           clr_mask[clr_rd]   = 1'b1;
  end

  // Busy update: clear applied first so a same-index re-issue wins.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= ((busy & ~clr_mask) | set_mask) & X0_MASK;
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: arbitrates ALU results and load
// responses onto the single write port, exposes the in-flight write as a
// bypass, and tracks pending loads for decode.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             ld_issue,
  input  logic [REG_W-1:0] ld_issue_rd,
  output logic             ld_issue_ready,
  input  logic             ld_valid,
  input  logic [REG_W-1:0] ld_rd,
  input  logic [XLEN-1:0]  ld_data,
  output logic             ld_ready,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  output logic             stall,
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [XLEN-1:0]  fwd_data,
  output logic [REG_W-1:0] wa,
  output logic [XLEN-1:0]  wd,
  output logic             we
);

  wb_req_t         alu_req, ld_req, sel;
  logic            wr_go;
  logic [NREG-1:0] busy;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign ld_req  = '{valid: ld_valid,  rd: ld_rd,  data: ld_data};

  // Handshakes: load responses always win; ALU waits out any load beat.
  always_comb begin
    ld_ready  = !rst;
    alu_ready = !rst && !ld_valid;
  end

  // Select the accepted source; x0 destinations are consumed but not written.
  always_comb begin
    sel = '0;
    if (ld_valid && ld_ready)        sel = ld_req;
    else if (alu_valid && alu_ready) sel = alu_req;
    wr_go = sel.valid && sel.rd != REG_ZERO;
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      we <= wr_go;
      if (wr_go) begin
        wa <= sel.rd;
        wd <= sel.data;
      end
    end
  end

  // Bypass of the write reg_file has not captured yet.
  always_comb begin
    fwd1_hit = we && wa == ra1 && wa != REG_ZERO;
    fwd2_hit = we && wa == ra2 && wa != REG_ZERO;
    fwd_data = wd;
  end

  wb_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_vld   (ld_issue),
    .issue_rd    (ld_issue_rd),
    .clr_vld     (ld_valid && ld_ready),
    .clr_rd      (ld_rd),
    .ra1         (ra1),
    .ra2         (ra2),
    .issue_ready (ld_issue_ready),
    .stall       (stall),
    .busy        (busy)
  );

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: reset, ALU writes, collisions,
// scoreboard set/clear, bypass and mid-operation reset.
module tb_reg_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  ra1, ra2;
  logic        stall, fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .ra1(ra1), .ra2(ra2), .stall(stall),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
    .wa(wa), .wd(wd), .we(we)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hCAFE0001;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    ra1 = '0; ra2 = '0;

    // Reset held two cycles with a live ALU request.
    step(); step();
    chk("rst_we", we, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_issue_ready", ld_issue_ready, 0);
    chk("rst_busy", dut.u_sb.busy, 0);
    chk("rst_stall", stall, 0);

    // ALU write x5.
    rst = 1'b0; alu_data = 32'hDEADBEEF; ra1 = 5'd5;
    #1 chk("alu_ready", alu_ready, 1);
    step();
    chk("alu_we", we, 1);
    chk("alu_wa", wa, 5);
    chk("alu_wd", wd, 32'hDEADBEEF);
    chk("alu_fwd1", fwd1_hit, 1);
    chk("alu_fwd_data", fwd_data, 32'hDEADBEEF);

    // ALU write to x0: accepted, no write, wa/wd hold.
    alu_rd = 5'd0; alu_data = 32'h00001234;
    #1 chk("x0_alu_ready", alu_ready, 1);
    step();
    chk("x0_we", we, 0);
    chk("x0_wa_hold", wa, 5);
    chk("x0_wd_hold", wd, 32'hDEADBEEF);
    chk("x0_fwd1", fwd1_hit, 0);

    // Collision: load wins, ALU held.
    alu_rd = 5'd3; alu_data = 32'h33;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h11;
    #1 chk("col_alu_ready", alu_ready, 0);
    chk("col_ld_ready", ld_ready, 1);
    step();
    chk("col1_we", we, 1);
    chk("col1_wa", wa, 4);
    chk("col1_wd", wd, 32'h11);
    ld_valid = 1'b0;
    #1 chk("col2_alu_ready", alu_ready, 1);
    step();
    chk("col2_wa", wa, 3);
    chk("col2_wd", wd, 32'h33);
    alu_valid = 1'b0;
    step();
    chk("idle_we", we, 0);
    chk("idle_wa_hold", wa, 3);

    // Scoreboard: issue x7, RAW stall, WAW block, response clears + bypass.
    ra1 = 5'd0; ra2 = 5'd7;
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    #1 chk("iss7_ready", ld_issue_ready, 1);
    chk("iss7_stall_pre", stall, 0);
    step();
    chk("iss7_stall", stall, 1);
    chk("iss7_ready2", ld_issue_ready, 0);
    ld_issue = 1'b0;
    step();
    chk("iss7_busy_held", stall, 1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h55;
    step();
    ld_valid = 1'b0;
    #1 chk("rsp7_stall", stall, 0);
    chk("rsp7_fwd2", fwd2_hit, 1);
    chk("rsp7_fwd_data", fwd_data, 32'h55);
    chk("rsp7_wa", wa, 7);
    chk("rsp7_issue_ready", ld_issue_ready, 1);

    // Same-cycle response and issue to x9 (x9 not busy): set wins, write occurs.
    ra2 = 5'd0; ra1 = 5'd9;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    #1 chk("sc9_issue_ready", ld_issue_ready, 1);
    step();
    ld_valid = 1'b0; ld_issue = 1'b0;
    #1 chk("sc9_stall", stall, 1);
    chk("sc9_we", we, 1);
    chk("sc9_wa", wa, 9);
    chk("sc9_wd", wd, 32'h99);

    // Mid-operation reset with x2, x10 pending and an ALU write in flight.
    ra1 = 5'd2; ra2 = 5'd10;
    ld_issue = 1'b1; ld_issue_rd = 5'd2;
    step();
    ld_issue_rd = 5'd10;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    step();
    ld_issue = 1'b0; alu_valid = 1'b0;
    #1 chk("mid_stall", stall, 1);
    chk("mid_we", we, 1);
    chk("mid_wa", wa, 6);
    rst = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'hBAD;
    #1 chk("mid_rst_ld_ready", ld_ready, 0);
    step();
    chk("mid_rst_we", we, 0);
    chk("mid_rst_wa", wa, 0);
    chk("mid_rst_wd", wd, 0);
    chk("mid_rst_busy", dut.u_sb.busy, 0);
    chk("mid_rst_stall", stall, 0);
    rst = 1'b0; ld_data = 32'h22;
    step();
    ld_valid = 1'b0;
    #1 chk("post_we", we, 1);
    chk("post_wa", wa, 2);
    chk("post_wd", wd, 32'h22);
    chk("post_fwd1", fwd1_hit, 1);
    step();
    chk("post_idle_we", we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
Write-side initiator for the 32x32 register file; it owns the single write port (wa/wd/we).
- Merges ALU results and load responses into one registered write per cycle.
- Keeps a pending-load scoreboard so decode can stall on RAW/WAW hazards.
- Supplies a bypass of the write in flight to both read ports.
- Sits between the execute/LSU stages and reg_file.

Parameters:
XLEN, 32, data width of ALU results, load data and wd
NREG, 32, number of architectural registers; x0 is hardwired to zero

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU result accepted this cycle (combinational)
ld_issue  in  1  a load is being issued this cycle
ld_issue_rd  in  5  destination register of the issued load
ld_issue_ready  out  1  issue permitted (combinational)
ld_valid  in  1  load response present
ld_rd  in  5  load response destination register
ld_data  in  XLEN  load response data
ld_ready  out  1  load response accepted (combinational)
ra1  in  5  decode read address 1
ra2  in  5  decode read address 2
stall  out  1  decode must hold: an operand is pending (combinational)
fwd1_hit  out  1  ra1 matches the write in flight
fwd2_hit  out  1  ra2 matches the write in flight
fwd_data  out  XLEN  data of the write in flight (equals wd)
wa  out  5  register file write address (registered)
wd  out  XLEN  register file write data (registered)
we  out  1  register file write enable (registered)

Behaviour:
- Reset: synchronous, active-high; no other reset exists.
  - Next edge with rst=1: we=0, wa=0, wd=0, busy[31:0]=0.
  - Combinational outputs are forced low while rst=1: alu_ready=0, ld_ready=0, ld_issue_ready=0.
  - Reset mid-operation: all outstanding busy bits are dropped; in-flight responses are ignored.
- Arbitration, one write per cycle, load has priority:
  - ld_ready = 1 when not in reset.
  - alu_ready = !ld_valid.
  - A transfer is accepted when valid && ready.
- Write latency is 1 cycle. The accepted source's rd/data appears on wa/wd with we=1 after the next edge.
- rd=0 writes: accepted (ready asserted) but the next-cycle we=0. wa/wd hold their previous values.
- No accepted source in a cycle: we=0 next cycle; wa/wd hold.
- Scoreboard busy[NREG-1:0]; busy[0] is always 0.
  - Issue rule: ld_issue_ready = !busy[ld_issue_rd] || ld_issue_rd==0. This blocks WAW behind a pending load.
  - Accepted issue with rd!=0 sets busy[rd] at the edge.
  - An accepted load response clears busy[ld_rd] at the edge.
  - Set and clear of the same index in one cycle: the set wins. This is only reachable when the response clears an index that is being re-issued.
  - A load response for a non-busy rd is still written. The bit stays 0.
- Hazard: stall = (busy[ra1] && ra1!=0) || (busy[ra2] && ra2!=0).
- Bypass: fwdN_hit = we && wa==raN && wa!=0; fwd_data = wd.
  - Covers the cycle in which reg_file has not yet captured wd.
  - A register that is busy and whose load is now in flight has busy=0 and fwd hit=1, so decode proceeds with the forwarded value.
- ALU starvation under back-to-back load responses is permitted. Upstream holds alu_valid and alu_rd/alu_data stable until alu_ready.

Decomposition:
- Shared package: XLEN, NREG, REG_ZERO=5'd0, and a wb_req_t grouping {valid, rd, data}.
- One sub-module, wb_scoreboard: the busy vector, set/clear logic, ld_issue_ready and stall.
- Arbitration, write register and bypass stay in the top.

Test Plan:
- Reset: hold rst for 2 cycles with alu_valid=1 -> we=0, wa=0, wd=0, alu_ready=0, busy all 0, stall=0.
- ALU write: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle we=1, wa=5, wd=0xDEADBEEF; ra1=5 gives fwd1_hit=1. With rd=0 -> we=0.
- Collision: alu_valid and ld_valid together, alu rd=3, ld rd=4 (0x11) -> cycle 1 writes x4=0x11 with alu_ready=0; ALU held, cycle 2 writes x3.
- Scoreboard path:
  - Issue load rd=7 -> stall=1 when ra2=7.
  - Second issue of rd=7 -> ld_issue_ready=0.
  - Response rd=7, 0x55 -> busy clears; next cycle fwd2_hit=1, fwd_data=0x55, stall=0.
- Same-cycle set/clear: response rd=9 accepted while a new issue rd=9 in the same cycle -> busy[9]=1 after the edge; write of x9 still occurs.
- Reset mid-operation: busy[2] and busy[10] set, assert rst -> busy cleared, we=0, a following response to rd=2 is written normally.
